// File: rtl/ysyx_25060166_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ysyx_25060166_ifu_prefetch
//
// Instruction fetch unit with a small prefetch queue. It owns the fetch PC and
// issues one instruction-memory request at a time over a valid/ready
// handshake. Each returned instruction is queued with its PC and handed to the
// IDU over a valid/ready interface. A redirect (jump/branch) flushes the queue
// and discards any response that is still in flight.
//
// Parameters:
//   XLEN     address / PC width
//   INST_W   instruction width
//   DEPTH    prefetch queue entries (power of two, >= 2)
//   RESET_PC fetch PC after reset
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   mem_req_valid   fetch request valid
//   mem_req_ready   memory accepts the request
//   mem_req_addr    fetch address (word aligned)
//   mem_rsp_valid   response valid (always accepted, no ready)
//   mem_rsp_data    returned instruction
//   redirect_valid  jump/branch taken (one-cycle pulse)
//   redirect_pc     new fetch PC
//   inst_valid      queue head valid
//   inst_ready      IDU consumes the head
//   inst_data       head instruction
//   inst_pc         head PC
//
// Optional feature (macro YSYX_25060166_IFU_PERF_EN):
//   perf_fetch_cnt  responses pushed into the queue (saturating)
//   perf_drop_cnt   responses discarded after a redirect (saturating)
// ---------------------------------------------------------------------------
module ysyx_25060166_ifu_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc
`ifdef YSYX_25060166_IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DROP} state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   req_addr;
  logic              drop_pending;
  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [INST_W-1:0] data_q [DEPTH];
  logic [XLEN-1:0]   pc_q   [DEPTH];

  logic handshake, push, pop, drop_rsp;
  logic unused_redirect_low;

  // The target's low two bits are forced to zero, so they are never needed.
  assign unused_redirect_low = ^redirect_pc[1:0];

  assign handshake = (state == ST_REQ) && mem_req_ready;
  // A response arriving together with a redirect belongs to the old path.
  assign push      = (state == ST_WAIT) && mem_rsp_valid && !redirect_valid;
  assign drop_rsp  = mem_rsp_valid &&
                     ((state == ST_DROP) || ((state == ST_WAIT) && redirect_valid));
  assign pop       = inst_valid && inst_ready && !redirect_valid;

  assign mem_req_valid = (state == ST_REQ);
  // Registered request address so it stays put while a redirect updates fetch_pc.
  assign mem_req_addr  = req_addr;
  assign inst_valid    = (count != '0);
  assign inst_data     = data_q[rd_ptr];
  assign inst_pc       = pc_q[rd_ptr];

  // A request is only started when the queue has room for its response, so a
  // push can never overflow even though responses have no backpressure.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (!redirect_valid && (count < FULL_CNT)) state_next = ST_REQ;
      ST_REQ:  if (mem_req_ready)
                 state_next = (drop_pending || redirect_valid) ? ST_DROP : ST_WAIT;
      ST_WAIT: if (mem_rsp_valid)       state_next = ST_IDLE;
               else if (redirect_valid) state_next = ST_DROP;
      ST_DROP: if (mem_rsp_valid)       state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state, fetch PC, request address and the drop-pending marker. A
  // redirect while a request waits for ready leaves that request untouched and
  // arranges for its response to be thrown away instead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      fetch_pc     <= {RESET_PC[XLEN-1:2], 2'b00};
      req_addr     <= {RESET_PC[XLEN-1:2], 2'b00};
      drop_pending <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == ST_IDLE) && (state_next == ST_REQ)) req_addr <= fetch_pc;
      if (redirect_valid)
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (handshake && !drop_pending)
        fetch_pc <= fetch_pc + XLEN'(4);
      if ((state == ST_REQ) && redirect_valid && !mem_req_ready)
        drop_pending <= 1'b1;
      else if ((state == ST_DROP) && mem_rsp_valid)
        drop_pending <= 1'b0;
    end
  end

  // Prefetch queue. A redirect empties it and overrides any same-cycle push or
  // pop; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect_valid) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= mem_rsp_data;
        pc_q[wr_ptr]   <= req_addr;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef YSYX_25060166_IFU_PERF_EN
  // Saturating event counters, cleared by reset only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (push && (perf_fetch_cnt != 32'hFFFF_FFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (drop_rsp && (perf_drop_cnt != 32'hFFFF_FFFF))
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_25060166_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25060166_ifu_prefetch
//
// Directed bench for the prefetching IFU. A behavioural instruction memory
// with configurable response latency answers each accepted request, and a
// queue of expected PCs (pushed whenever the bench starts or redirects a fetch
// stream) is popped and compared whenever the IDU side consumes an entry.
// Everything runs from one initial block: inputs change on the falling edge,
// outputs are sampled one time unit before the rising edge.
// ---------------------------------------------------------------------------
module tb_ysyx_25060166_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef YSYX_25060166_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle    = 0;
  int          req_count;
  int          rsp_lat;
  int          pend_cnt;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic [31:0] req_addrs[$];
  logic [31:0] exp_q[$];
  int          pop_cycles[$];

  always #5 clk = ~clk;

  ysyx_25060166_ifu_prefetch #(
    .XLEN(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef YSYX_25060166_IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  // Instruction word the memory returns for an address (addi-style low byte).
  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Just before the rising edge: record handshakes and score consumed entries.
  task automatic sampleEdge();
    if (rst && mem_req_valid && mem_req_ready) begin
      req_count++;
      req_addrs.push_back(mem_req_addr);
      checkOutput("req_align", {30'd0, mem_req_addr[1:0]}, 32'd0);
      pend_valid = 1'b1;
      pend_cnt   = rsp_lat;
      pend_addr  = mem_req_addr;
    end
    if (rst && inst_valid && inst_ready && !redirect_valid) begin
      pop_cycles.push_back(cycle);
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_pop", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checkOutput("sb_pc", inst_pc, e);
        checkOutput("sb_data", inst_data, dataOf(e));
      end
    end
  endtask

  // Falling edge: the memory model presents any response that is due.
  task automatic driveNegedge();
    @(negedge clk);
    cycle++;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (pend_valid) begin
      if (pend_cnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = dataOf(pend_addr);
        pend_valid    = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      #4;
      sampleEdge();
      driveNegedge();
    end
  endtask

  task automatic pushStream(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Quiesce the memory, then hold the DUT in reset; leaves rst low.
  task automatic doReset();
    mem_req_ready  = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    applyStimulus(5);
    rst = 1'b0;
    applyStimulus(2);
    exp_q.delete();
    req_addrs.delete();
    pop_cycles.delete();
    req_count  = 0;
    pend_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    req_count      = 0;
    rsp_lat        = 0;
    pend_cnt       = 0;
    pend_valid     = 1'b0;
    pend_addr      = '0;
    @(negedge clk);
    applyStimulus(2);

    // Reset state
    checkOutput("rst_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_inst_data", inst_data, 32'd0);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);
`ifdef YSYX_25060166_IFU_PERF_EN
    checkOutput("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    checkOutput("rst_perf_drop", perf_drop_cnt, 32'd0);
`endif

    // Streaming with a zero-wait memory: one instruction every 3 cycles
    $display("[TB] phase 1: streaming fetch");
    mem_req_ready = 1'b1;
    inst_ready    = 1'b1;
    pushStream(32'h8000_0000);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("p1_first_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("p1_first_addr", mem_req_addr, 32'h8000_0000);
    for (int k = 0; k < 20 && pop_cycles.size() < 3; k++) applyStimulus(1);
    checkOutput("p1_pops", 32'(pop_cycles.size()), 32'd3);
    checkOutput("p1_gap0", 32'(pop_cycles[1] - pop_cycles[0]), 32'd3);
    checkOutput("p1_gap1", 32'(pop_cycles[2] - pop_cycles[1]), 32'd3);

    // Queue full: exactly DEPTH requests, then fetch resumes after a pop
    $display("[TB] phase 2: queue full");
    doReset();
    mem_req_ready = 1'b1;
    pushStream(32'h8000_0000);
    rst = 1'b1;
    for (int k = 0; k < 30 && req_count < 4; k++) applyStimulus(1);
    applyStimulus(8);
    checkOutput("p2_req_count", 32'(req_count), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("p2_req_addr", req_addrs[i], 32'h8000_0000 + 32'(4 * i));
    checkOutput("p2_full_idle", 32'(mem_req_valid), 32'd0);
    checkOutput("p2_full_valid", 32'(inst_valid), 32'd1);
    checkOutput("p2_head_pc", inst_pc, 32'h8000_0000);
    inst_ready = 1'b1;
    applyStimulus(1);
    checkOutput("p2_no_bypass", 32'(mem_req_valid), 32'd0);
    applyStimulus(1);
    checkOutput("p2_resume_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("p2_resume_addr", mem_req_addr, 32'h8000_0010);
    applyStimulus(6);

    // Request held while the memory is not ready
    $display("[TB] phase 3: request stall");
    doReset();
    inst_ready = 1'b1;
    pushStream(32'h8000_0000);
    rst = 1'b1;
    applyStimulus(1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("p3_hold_valid", 32'(mem_req_valid), 32'd1);
      checkOutput("p3_hold_addr", mem_req_addr, 32'h8000_0000);
      applyStimulus(1);
    end
    checkOutput("p3_no_early_hs", 32'(req_count), 32'd0);
    mem_req_ready = 1'b1;
    applyStimulus(1);
    checkOutput("p3_hs_count", 32'(req_count), 32'd1);
    checkOutput("p3_hs_addr", req_addrs[0], 32'h8000_0000);
    applyStimulus(6);

    // Redirect while waiting for a response, with two entries queued
    $display("[TB] phase 4: redirect in WAIT");
    doReset();
    mem_req_ready = 1'b1;
    rsp_lat       = 2;
    pushStream(32'h8000_0000);
    rst = 1'b1;
    for (int k = 0; k < 40 && req_count < 3; k++) applyStimulus(1);
    checkOutput("p4_req3", 32'(req_count), 32'd3);
    checkOutput("p4_queued", 32'(inst_valid), 32'd1);
    checkOutput("p4_head_pc", inst_pc, 32'h8000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    inst_ready     = 1'b1;
    applyStimulus(1);
    redirect_valid = 1'b0;
    pushStream(32'h8000_0100);
    checkOutput("p4_flushed", 32'(inst_valid), 32'd0);
    for (int k = 0; k < 10 && !mem_req_valid; k++) applyStimulus(1);
    checkOutput("p4_redir_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("p4_redir_addr", mem_req_addr, 32'h8000_0100);
`ifdef YSYX_25060166_IFU_PERF_EN
    checkOutput("p4_perf_drop", perf_drop_cnt, 32'd1);
    checkOutput("p4_perf_fetch", perf_fetch_cnt, 32'd2);
`endif
    for (int k = 0; k < 20 && pop_cycles.size() < 1; k++) applyStimulus(1);
    checkOutput("p4_pop_after_redir", 32'(pop_cycles.size()), 32'd1);
    checkOutput("p4_req_after_redir", req_addrs[3], 32'h8000_0100);

    // Redirect while the request is stalled on ready
    $display("[TB] phase 5: redirect in REQ");
    doReset();
    rsp_lat    = 0;
    inst_ready = 1'b1;
    pushStream(32'h8000_0000);
    rst = 1'b1;
    applyStimulus(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0202;
    applyStimulus(1);
    redirect_valid = 1'b0;
    pushStream(32'h8000_0200);
    checkOutput("p5_addr_stable", mem_req_addr, 32'h8000_0000);
    checkOutput("p5_valid_stable", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    for (int k = 0; k < 10 && req_count < 2; k++) applyStimulus(1);
    checkOutput("p5_req_count", 32'(req_count), 32'd2);
    checkOutput("p5_old_addr", req_addrs[0], 32'h8000_0000);
    checkOutput("p5_new_addr", req_addrs[1], 32'h8000_0200);
    for (int k = 0; k < 10 && pop_cycles.size() < 1; k++) applyStimulus(1);
    checkOutput("p5_pop", 32'(pop_cycles.size()), 32'd1);
`ifdef YSYX_25060166_IFU_PERF_EN
    checkOutput("p5_perf_drop", perf_drop_cnt, 32'd1);
`endif

    // Asynchronous reset in WAIT with two entries queued
    $display("[TB] phase 6: reset mid-WAIT");
    doReset();
    mem_req_ready = 1'b1;
    rsp_lat       = 2;
    pushStream(32'h8000_0000);
    rst = 1'b1;
    for (int k = 0; k < 40 && req_count < 3; k++) applyStimulus(1);
    checkOutput("p6_req3", 32'(req_count), 32'd3);
    checkOutput("p6_queued", 32'(inst_valid), 32'd1);
    #2;
    rst           = 1'b0;
    mem_req_ready = 1'b0;
    #1;
    checkOutput("p6_async_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("p6_async_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("p6_async_inst_pc", inst_pc, 32'd0);
    #1;
    sampleEdge();
    driveNegedge();
    rst = 1'b1;
    pushStream(32'h8000_0000);
    applyStimulus(1);
    checkOutput("p6_first_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("p6_first_addr", mem_req_addr, 32'h8000_0000);
    applyStimulus(1);
    checkOutput("p6_late_ignored0", 32'(inst_valid), 32'd0);
    applyStimulus(1);
    checkOutput("p6_late_ignored1", 32'(inst_valid), 32'd0);
    mem_req_ready = 1'b1;
    inst_ready    = 1'b1;
    for (int k = 0; k < 10 && pop_cycles.size() < 1; k++) applyStimulus(1);
    checkOutput("p6_pop", 32'(pop_cycles.size()), 32'd1);
    applyStimulus(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25060166_ifu_prefetch.md
Name: ysyx_25060166_ifu_prefetch

Overview:
- Parametrised successor to the single-cycle fetch path. Today the fetch address is wired straight from the PC, and jumps are tied off.
- Owns the fetch PC and issues handshaked instruction-memory requests, one outstanding at a time.
- Buffers returned instructions with their PCs in a DEPTH-entry queue and hands them to the IDU over a valid/ready interface.
- Supports jump/branch redirect with queue flush and discard of in-flight responses.

Parameters:
- XLEN, 32, address/PC width.
- INST_W, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, ≥2.
- RESET_PC, 32'h8000_0000, fetch PC after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  fetch address, low 2 bits always 0.
- mem_rsp_valid  in  1  response valid; this block always accepts it, no ready.
- mem_rsp_data  in  INST_W  returned instruction.
- redirect_valid  in  1  jump/branch taken, one-cycle pulse.
- redirect_pc  in  XLEN  new fetch PC.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  IDU consumes head.
- inst_data  out  INST_W  head instruction.
- inst_pc  out  XLEN  head PC.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, fetch_pc=RESET_PC, queue count=0, rd/wr ptr=0, drop_pending=0.
  - mem_req_valid=0, inst_valid=0; inst_data/inst_pc=0.
- Request FSM, mem_req_valid = (state==REQ):
  - IDLE→REQ when count < DEPTH and no redirect this cycle.
  - REQ: mem_req_addr = fetch_pc, held stable until handshake (valid&ready).
    - On handshake: fetch_pc += 4.
    - Next state is WAIT, or DROP if drop_pending or redirect this cycle.
  - WAIT: on mem_rsp_valid, push {fetch address, mem_rsp_data} into queue, →IDLE.
  - DROP: on mem_rsp_valid, discard data, clear drop_pending, →IDLE.
- Space reservation: a request is issued only with a free slot. Pops can only free space, so a response push never overflows. No response backpressure.
- Queue: inst_valid = (count≠0); head fields registered. Pop on inst_valid&inst_ready.
  - Push lands in the queue the cycle after mem_rsp_valid; no bypass.
  - Push+pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: first mem_req_valid is 1 cycle after rst deasserts. Best case with a 0-wait memory is 1 instruction per 3 cycles (IDLE→REQ→WAIT); this is intended.
- Redirect (highest priority), in the cycle redirect_valid=1:
  - fetch_pc ← {redirect_pc[XLEN-1:2],2'b00}.
  - Queue flushed (count=0, ptrs=0) next cycle. A same-cycle pop or push is discarded.
  - In REQ without handshake: address stays stable, drop_pending=1.
    - The old request completes, its response is dropped, and the new PC is fetched after.
    - fetch_pc is not incremented on that handshake.
  - In WAIT: →DROP.
  - In IDLE/DROP: state unchanged.
- Back-to-back redirects: the last one wins; at most one response is dropped per outstanding request.
- Queue full: stays IDLE, mem_req_valid=0 until a pop.
- mem_rsp_valid in IDLE/REQ is a protocol error; it is ignored and nothing is pushed.

Optional Feature:
- Macro YSYX_25060166_IFU_PERF_EN.
- When defined, adds output ports perf_fetch_cnt (32) and perf_drop_cnt (32):
  - perf_fetch_cnt increments on each accepted response pushed.
  - perf_drop_cnt increments on each response discarded in DROP.
  - Both reset to 0, saturate at 32'hFFFF_FFFF, and are flushed by reset only.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, mem_req_ready=1, 0-wait memory returning 32'h0000_0013, inst_ready=1 → first mem_req_addr=32'h8000_0000; inst_pc sequence 8000_0000, 8000_0004, 8000_0008, one per 3 cycles.
- inst_ready=0, DEPTH=4 → exactly 4 requests issued (…000 to …00C), then mem_req_valid stays 0; raise inst_ready → 5th request at 32'h8000_0010 after first pop.
- mem_req_ready=0 for 5 cycles → mem_req_addr held at 32'h8000_0000 and valid stays 1 throughout; handshake on cycle 6.
- Redirect to 32'h8000_0100 while in WAIT → in-flight response dropped; queue empty next cycle; next request addr 32'h8000_0100; with PERF_EN, perf_drop_cnt=1.
- Redirect to 32'h8000_0202 during REQ with ready=0 → old address completes and its response is dropped; next request 32'h8000_0200.
- Assert rst mid-WAIT with 2 queued entries → inst_valid=0 immediately; after release, first request 32'h8000_0000; the late response is ignored.
